// File: rtl/fan_buffer.sv
// fan_buffer: registered 1-to-N fanout, one holding slot per channel.
// Define FAN_TRISTATE_EN to float the data of empty channels (z).
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module fan_buffer #(
    parameter int SIGNAL_WIDTH = `REG_WIDTH,
    parameter int CHANNELS = 16,
    localparam int SEL_WIDTH = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SIGNAL_WIDTH-1:0]      in,
    input  logic [SEL_WIDTH-1:0]         selector,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CHANNELS*SIGNAL_WIDTH-1:0] out,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ack,
    output logic                         err,
    input  logic                         err_clr
);

    localparam int SEL_N = 1 << SEL_WIDTH;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state_q [CHANNELS];
    state_t                  state_d [CHANNELS];
    logic [SIGNAL_WIDTH-1:0] data_q  [CHANNELS];
    logic [SIGNAL_WIDTH-1:0] data_d  [CHANNELS];
    logic                    err_q;
    logic                    err_d;

    logic [SEL_N-1:0]    sel_ok;
    logic [SEL_N-1:0]    sel_full;
    logic [SEL_N-1:0]    sel_ack;
    logic [CHANNELS-1:0] hit;
    logic                drop;
    logic                xfer;

    // Pad per-channel flags out to the full selector range so that
    // out-of-range indices read as "not a channel" instead of X.
    for (genvar i = 0; i < SEL_N; i++) begin : g_sel
        if (i < CHANNELS) begin : g_real
            assign sel_ok[i]   = 1'b1;
            assign sel_full[i] = (state_q[i] == FULL);
            assign sel_ack[i]  = out_ack[i];
        end else begin : g_pad
            assign sel_ok[i]   = 1'b0;
            assign sel_full[i] = 1'b0;
            assign sel_ack[i]  = 1'b0;
        end
    end

    assign drop     = !sel_ok[selector];
    assign in_ready = drop || !sel_full[selector] || sel_ack[selector];
    assign xfer     = in_valid && in_ready;

    always_comb begin
        err_d = err_q;
        for (int k = 0; k < CHANNELS; k++) begin
            hit[k]     = xfer && !drop && (selector == SEL_WIDTH'(k));
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            unique case (state_q[k])
                EMPTY: begin
                    if (hit[k]) begin
                        state_d[k] = FULL;
                        data_d[k]  = in;
                    end
                end
                FULL: begin
                    if (hit[k]) begin
                        data_d[k] = in;
                    end else if (out_ack[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
        end
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (xfer && drop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            err_q <= err_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_out
        assign out_valid[k] = (state_q[k] == FULL);
`ifdef FAN_TRISTATE_EN
        assign out[k*SIGNAL_WIDTH +: SIGNAL_WIDTH] =
            out_valid[k] ? data_q[k] : {SIGNAL_WIDTH{1'bz}};
`else
        assign out[k*SIGNAL_WIDTH +: SIGNAL_WIDTH] = data_q[k];
`endif
    end

    assign err = err_q;

endmodule

// File: tb/tb_fan_buffer.sv
// tb_fan_buffer: directed and random checks of fan_buffer (16 and 12
// channels) against a slot-level behavioural model.
`timescale 1ns/1ps

module tb_fan_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   sel16 = '0;
    logic [7:0]   din16 = '0;
    logic         vld16 = 1'b0;
    logic [15:0]  ack16 = '0;
    logic         clr16 = 1'b0;
    logic         rdy16;
    logic [127:0] out16;
    logic [15:0]  ov16;
    logic         err16;

    logic [3:0]   sel12 = '0;
    logic [7:0]   din12 = '0;
    logic         vld12 = 1'b0;
    logic [11:0]  ack12 = '0;
    logic         clr12 = 1'b0;
    logic         rdy12;
    logic [95:0]  out12;
    logic [11:0]  ov12;
    logic         err12;

    fan_buffer #(.SIGNAL_WIDTH(8), .CHANNELS(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in(din16), .selector(sel16),
        .in_valid(vld16), .in_ready(rdy16), .out(out16),
        .out_valid(ov16), .out_ack(ack16), .err(err16),
        .err_clr(clr16)
    );

    fan_buffer #(.SIGNAL_WIDTH(8), .CHANNELS(12)) u12 (
        .clk(clk), .rst_n(rst_n), .in(din12), .selector(sel12),
        .in_valid(vld12), .in_ready(rdy12), .out(out12),
        .out_valid(ov12), .out_ack(ack12), .err(err12),
        .err_clr(clr12)
    );

    int errors = 0;
    int checks = 0;

    // Model: index 0 is the 16-channel DUT, index 1 the 12-channel one.
    bit         mfull [2][16];
    logic [7:0] mdata [2][16];
    bit         merr  [2];

    function automatic int nch(input int m);
        return (m == 0) ? 16 : 12;
    endfunction

    function automatic bit mready(input int m, input int sel,
                                  input logic [15:0] ack);
        if (sel >= nch(m)) return 1'b1;
        return !mfull[m][sel] || ack[sel];
    endfunction

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) begin
                mfull[m][k] = 1'b0;
                mdata[m][k] = 8'h00;
            end
            merr[m] = 1'b0;
        end
    endtask

    task automatic mupdate(input int m, input int sel, input logic [7:0] d,
                           input bit vld, input logic [15:0] ack,
                           input bit clr);
        bit go;
        go = vld && mready(m, sel, ack);
        for (int k = 0; k < nch(m); k++) begin
            if (go && sel == k) begin
                mfull[m][k] = 1'b1;
                mdata[m][k] = d;
            end else if (ack[k]) begin
                mfull[m][k] = 1'b0;
            end
        end
        if (clr) merr[m] = 1'b0;
        if (go && sel >= nch(m)) merr[m] = 1'b1;
    endtask

    function automatic logic [7:0] mout(input int m, input int k);
`ifdef FAN_TRISTATE_EN
        return mfull[m][k] ? mdata[m][k] : 8'hzz;
`else
        return mdata[m][k];
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (rst_n) begin
            mupdate(0, int'(sel16), din16, vld16, ack16, clr16);
            mupdate(1, int'(sel12), din12, vld12, {4'h0, ack12}, clr12);
        end else begin
            mreset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [127:0] e16, e12, v16, v12;
        e16 = '0; e12 = '0; v16 = '0; v12 = '0;
        for (int k = 0; k < 16; k++) begin
            e16[k*8 +: 8] = mout(0, k);
            v16[k] = mfull[0][k];
        end
        for (int k = 0; k < 12; k++) begin
            e12[k*8 +: 8] = mout(1, k);
            v12[k] = mfull[1][k];
        end
        #1;
        chk({tag, ".out16"}, out16, e16);
        chk({tag, ".ov16"}, {112'h0, ov16}, v16);
        chk({tag, ".err16"}, {127'h0, err16}, {127'h0, merr[0]});
        chk({tag, ".rdy16"}, {127'h0, rdy16},
            {127'h0, mready(0, int'(sel16), ack16)});
        chk({tag, ".out12"}, {32'h0, out12}, e12);
        chk({tag, ".ov12"}, {116'h0, ov12}, v12);
        chk({tag, ".err12"}, {127'h0, err12}, {127'h0, merr[1]});
        chk({tag, ".rdy12"}, {127'h0, rdy12},
            {127'h0, mready(1, int'(sel12), {4'h0, ack12})});
    endtask

    initial begin
        bit st16, st12;
        mreset();
        step();
        step();
        rst_n = 1'b1;
        step();
        check_all("reset");
        chk("reset.rdy_const", {127'h0, rdy16}, 128'h1);

        // Spurious acks on empty channels change nothing.
        ack16 = 16'hFFFF;
        step();
        ack16 = '0;
        chk("spurious.ov", {112'h0, ov16}, 128'h0);
        check_all("spurious");

        // Single write to channel 5, then ack.
        sel16 = 4'd5; din16 = 8'hA5; vld16 = 1'b1;
        #1 chk("single.rdy", {127'h0, rdy16}, 128'h1);
        step();
        vld16 = 1'b0;
        chk("single.ov", {112'h0, ov16}, 128'h0020);
        chk("single.ch5", {120'h0, out16[40 +: 8]}, 128'hA5);
        check_all("single");
        ack16 = 16'h0020;
        step();
        ack16 = '0;
        chk("single.ack_ov", {112'h0, ov16}, 128'h0);
        check_all("single_ack");

        // Backpressure on channel 2.
        sel16 = 4'd2; din16 = 8'h11; vld16 = 1'b1;
        step();
        din16 = 8'h22;
        #1 chk("bp.stall_rdy", {127'h0, rdy16}, 128'h0);
        step();
        chk("bp.hold", {120'h0, out16[16 +: 8]}, 128'h11);
        check_all("bp_hold");
        ack16 = 16'h0004;
        #1 chk("bp.ack_rdy", {127'h0, rdy16}, 128'h1);
        step();
        vld16 = 1'b0; ack16 = '0;
        chk("bp.reload", {120'h0, out16[16 +: 8]}, 128'h22);
        chk("bp.ov2", {127'h0, ov16[2]}, 128'h1);
        check_all("bp_reload");

        // Rotating stream 0..15 without acks.
        ack16 = 16'hFFFF;
        step();
        ack16 = '0;
        for (int k = 0; k < 16; k++) begin
            sel16 = 4'(k); din16 = 8'(k); vld16 = 1'b1;
            #1 chk("rot.rdy", {127'h0, rdy16}, 128'h1);
            step();
        end
        vld16 = 1'b0;
        chk("rot.ov", {112'h0, ov16}, 128'hFFFF);
        check_all("rot");

        // Asynchronous reset mid-stream with channels 3 and 7 full.
        ack16 = 16'hFFFF;
        step();
        ack16 = '0;
        sel16 = 4'd3; din16 = 8'h33; vld16 = 1'b1;
        step();
        sel16 = 4'd7; din16 = 8'h77;
        step();
        sel16 = 4'd9; din16 = 8'h99;
        chk("pre_rst.ov", {112'h0, ov16}, 128'h0088);
        #2 rst_n = 1'b0;
        mreset();
        #1;
        chk("rst.ov", {112'h0, ov16}, 128'h0);
        chk("rst.err", {127'h0, err16}, 128'h0);
        chk("rst.rdy", {127'h0, rdy16}, 128'h1);
        check_all("rst_async");
        step();
        vld16 = 1'b0;
        rst_n = 1'b1;
        step();
        check_all("rst_release");

        // Out-of-range writes on the 12-channel instance.
        sel12 = 4'd13; din12 = 8'h3C; vld12 = 1'b1;
        #1 chk("oor.rdy", {127'h0, rdy12}, 128'h1);
        step();
        vld12 = 1'b0;
        chk("oor.err", {127'h0, err12}, 128'h1);
        chk("oor.ov", {116'h0, ov12}, 128'h0);
        check_all("oor");
        vld12 = 1'b1; clr12 = 1'b1;
        step();
        vld12 = 1'b0;
        chk("oor.set_wins", {127'h0, err12}, 128'h1);
        step();
        clr12 = 1'b0;
        chk("oor.clr", {127'h0, err12}, 128'h0);
        check_all("oor_clr");

        // Random traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            st16 = vld16 && !mready(0, int'(sel16), ack16);
            st12 = vld12 && !mready(1, int'(sel12), {4'h0, ack12});
            step();
            if (!st16) begin
                sel16 = 4'($urandom_range(0, 15));
                din16 = 8'($urandom);
                vld16 = 1'($urandom_range(0, 1));
            end
            if (!st12) begin
                sel12 = 4'($urandom_range(0, 15));
                din12 = 8'($urandom);
                vld12 = 1'($urandom_range(0, 1));
            end
            ack16 = 16'($urandom & $urandom);
            ack12 = 12'($urandom & $urandom);
            clr16 = ($urandom_range(0, 15) == 0);
            clr12 = ($urandom_range(0, 7) == 0);
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fan_buffer.md
# fan_buffer

Parametrised, registered 1-to-N fanout with one holding slot per channel and a valid/ready/ack handshake. It is the successor to the combinational 1-to-16 fanout. A single producer (bus or CPU-side writer) steers a word to one of `CHANNELS` consumers; each consumer sees its word until it acknowledges it. Used wherever a shared internal data bus feeds several register-file or peripheral sinks that may not consume in the same cycle.

## Interface
Parameters:
- `SIGNAL_WIDTH`, default `` `REG_WIDTH `` (8): data word width.
- `CHANNELS`, default 16: number of output channels, range 2..64.
- `SEL_WIDTH`: derived localparam, `$clog2(CHANNELS)`. Not overridable.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in`  in  `SIGNAL_WIDTH`  write data.
- `selector`  in  `SEL_WIDTH`  target channel index.
- `in_valid`  in  1  producer has a word this cycle.
- `in_ready`  out  1  combinational; transfer occurs when `in_valid && in_ready`.
- `out`  out  `CHANNELS*SIGNAL_WIDTH`  flattened channel data; channel k is `out[k*SIGNAL_WIDTH +: SIGNAL_WIDTH]`.
- `out_valid`  out  `CHANNELS`  per-channel slot-full flag.
- `out_ack`  in  `CHANNELS`  per-channel consume strobe.
- `err`  out  1  sticky: a word was dropped because `selector >= CHANNELS`.
- `err_clr`  in  1  synchronous clear for `err`.

## Operation
- Each channel is a two-state machine, EMPTY/FULL, with a `SIGNAL_WIDTH` data register.
- EMPTY -> FULL: transfer to that channel. FULL -> EMPTY: `out_ack[k]` with no transfer to k in the same cycle. FULL -> FULL: `out_ack[k]` and a transfer to k in the same cycle; the data register reloads and `out_valid[k]` stays 1.
- `in_ready` rules:
  - When `selector >= CHANNELS`: 1. The word is accepted and discarded, and `err` sets on that edge.
  - Otherwise: `!out_valid[selector] || out_ack[selector]`.
- Only the selected channel is affected by a transfer. Other channels hold state.
- `out_ack[k]` while channel k is EMPTY is ignored.
- `err`: set takes priority over `err_clr` in the same cycle.
- `in_ready` is a function of `selector`, `out_valid` and `out_ack` only. It does not depend on `in_valid`. Producers must hold `in` and `selector` stable while `in_valid && !in_ready`.

## Timing
- Reset (asynchronous, any time, including mid-transfer): all channels go EMPTY, all data registers go to 0, `out_valid` = 0, `err` = 0. Any transfer on the reset edge is lost.
- Outputs after reset: `out` is all-z with `FAN_TRISTATE_EN`, all-0 without. `in_ready` is 1, combinationally.
- Latency: a transfer on edge N gives `out_valid[k]` = 1 and new data on `out` immediately after edge N (1 cycle).
- Ack latency: `out_ack[k]` sampled on edge N clears `out_valid[k]` after edge N. `in_ready` for channel k rises combinationally in the same cycle `out_ack[k]` is high.
- Throughput: one word per cycle, provided consumers ack in the cycle after valid or the target rotates.

## Configuration
- `FAN_TRISTATE_EN` defined: channel k drives its data only while `out_valid[k]` = 1, and drives `{SIGNAL_WIDTH{1'bz}}` when EMPTY. This is for shared-net sinks.
- `FAN_TRISTATE_EN` undefined: channel k always drives its data register, holding the last written value after ack. 0 after reset. No z is ever driven.

## Test plan
All scenarios use `SIGNAL_WIDTH`=8, `CHANNELS`=16 unless noted.
- Reset/idle: assert `rst_n`=0 mid-stream with channels 3 and 7 FULL. Required: `out_valid`=0 immediately, `err`=0, `in_ready`=1; `out` is z per channel (macro on) or 0x00 (macro off).
- Single write: `selector`=5, `in`=0xA5, `in_valid` for 1 cycle. Required: next cycle `out_valid`=16'h0020 and channel 5 = 0xA5. Hold `out_ack[5]` 1 cycle -> `out_valid`=0. With the macro off, channel 5 remains 0xA5.
- Backpressure: channel 2 FULL with 0x11, write 0x22 to channel 2 with no ack. Required: `in_ready`=0 and channel 2 keeps 0x11. Then assert `out_ack[2]` in the same cycle -> `in_ready`=1, and next cycle channel 2 = 0x22 with `out_valid[2]` still 1.
- Rotating stream: write 0x00..0x0F to channels 0..15 on consecutive cycles with no acks. Required: `in_ready`=1 for all 16 cycles, `out_valid`=16'hFFFF, and channel k = k.
- Out-of-range (`CHANNELS`=12): write 0x3C with `selector`=13. Required: `in_ready`=1, no `out_valid` change, `err`=1 next cycle. `err_clr` with a simultaneous bad write keeps `err`=1; `err_clr` alone clears it.
- Spurious ack: pulse `out_ack`=16'hFFFF with all channels EMPTY. Required: no state change, `out_valid` stays 0.
